// File: rtl/seq_stream_pkg.sv
// Shared constants and types for the sequence stream monitor.
// Holds the counter's sequence table and the code legality map.
package seq_stream_pkg;

  localparam int IDX_W   = 3;
  localparam int SEQ_LEN = 8;

  typedef enum logic [1:0] {
    S_HUNT   = 2'd0,
    S_VERIFY = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  // Element [0] is the first code of the lap.
  localparam logic [SEQ_LEN-1:0][3:0] SEQ_TAB = {
    4'h6, 4'h9, 4'hB, 4'hD,
    4'hF, 4'h7, 4'hE, 4'h0
  };

  // One bit per 4-bit code; set for 1,2,3,4,5,8,A,C.
  localparam logic [15:0] ILLEGAL_MASK = 16'h153E;

  function automatic logic is_illegal(
    input logic [3:0] code
  );
    return ILLEGAL_MASK[code];
  endfunction

endpackage

// File: rtl/seq_stream_monitor_if.sv
// Sample stream in, monitor status out.
// master drives samples; slave is the monitor.
interface seq_stream_monitor_if
  import seq_stream_pkg::*;
#(
  parameter int LAP_W = 8,
  parameter int ERR_W = 8
);

  logic             en;
  logic [3:0]       seq_in;
  logic             locked;
  logic [IDX_W-1:0] pos;
  logic             wrap;
  logic             err;
  logic [LAP_W-1:0] laps;
  logic [ERR_W-1:0] errs;

  modport master (
    output en, seq_in,
    input  locked, pos, wrap, err,
    input  laps, errs
  );

  modport slave (
    input  en, seq_in,
    output locked, pos, wrap, err,
    output laps, errs
  );

endinterface

// File: rtl/seq_code_decode.sv
// Maps a 4-bit code to its legality and
// its position in the sequence table.
module seq_code_decode
  import seq_stream_pkg::*;
(
  input  logic [3:0]       code,
  output logic             legal,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    legal = !is_illegal(code);
    idx   = '0;
    for (int i = 0; i < SEQ_LEN; i++) begin
      if (SEQ_TAB[i] == code) begin
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/seq_stream_monitor.sv
// Hunts for, locks onto and checks the 8-state
// counter sequence; counts laps and errors.
module seq_stream_monitor
  import seq_stream_pkg::*;
#(
  parameter int LOCK_N = 3,
  parameter int LAP_W  = 8,
  parameter int ERR_W  = 8
) (
  input logic                clk,
  input logic                clr,
  seq_stream_monitor_if.slave mon
);

  localparam logic [3:0] LOCK_C = 4'(LOCK_N);

  state_t           state, state_n;
  logic [IDX_W-1:0] exp_idx, exp_n;
  logic [3:0]       cnt, cnt_n;
  logic [IDX_W-1:0] pos_q, pos_n;
  logic             wrap_q, wrap_n;
  logic             err_q, err_n;
  logic [LAP_W-1:0] laps_q, laps_n;
  logic [ERR_W-1:0] errs_q, errs_n;

  logic             legal;
  logic [IDX_W-1:0] idx;
  logic             hit;

  seq_code_decode u_dec (
    .code  (mon.seq_in),
    .legal (legal),
    .idx   (idx)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state   <= S_HUNT;
      exp_idx <= '0;
      cnt     <= '0;
      pos_q   <= '0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
      laps_q  <= '0;
      errs_q  <= '0;
    end else begin
      state   <= state_n;
      exp_idx <= exp_n;
      cnt     <= cnt_n;
      pos_q   <= pos_n;
      wrap_q  <= wrap_n;
      err_q   <= err_n;
      laps_q  <= laps_n;
      errs_q  <= errs_n;
    end
  end

  always_comb begin
    state_n = state;
    exp_n   = exp_idx;
    cnt_n   = cnt;
    pos_n   = pos_q;
    wrap_n  = 1'b0;
    err_n   = 1'b0;
    laps_n  = laps_q;
    errs_n  = errs_q;
    hit     = (mon.seq_in == SEQ_TAB[exp_idx]);
    if (mon.en) begin
      unique case (state)
        S_HUNT: begin
          if (legal) begin
            state_n = S_VERIFY;
            exp_n   = idx + 3'd1;
            cnt_n   = 4'd1;
          end
        end
        S_VERIFY: begin
          if (hit) begin
            cnt_n = cnt + 4'd1;
            exp_n = exp_idx + 3'd1;
            if (cnt_n == LOCK_C) begin
              state_n = S_LOCKED;
              pos_n   = idx;
            end
          end else if (legal) begin
            exp_n = idx + 3'd1;
            cnt_n = 4'd1;
          end else begin
            state_n = S_HUNT;
            exp_n   = '0;
            cnt_n   = '0;
          end
        end
        S_LOCKED: begin
          if (hit) begin
            exp_n = exp_idx + 3'd1;
            pos_n = idx;
            if (idx == '0) begin
              wrap_n = 1'b1;
              if (laps_q != '1) laps_n = laps_q + 1'b1;
            end
          end else begin
            err_n = 1'b1;
            pos_n = '0;
            if (errs_q != '1) errs_n = errs_q + 1'b1;
            if (legal) begin
              state_n = S_VERIFY;
              exp_n   = idx + 3'd1;
              cnt_n   = 4'd1;
            end else begin
              state_n = S_HUNT;
              exp_n   = '0;
              cnt_n   = '0;
            end
          end
        end
        default: begin
          state_n = S_HUNT;
          exp_n   = '0;
          cnt_n   = '0;
        end
      endcase
    end
  end

  assign mon.locked = (state == S_LOCKED);
  assign mon.pos    = pos_q;
  assign mon.wrap   = wrap_q;
  assign mon.err    = err_q;
  assign mon.laps   = laps_q;
  assign mon.errs   = errs_q;

endmodule

// File: doc/seq_stream_monitor.md
Name: seq_stream_monitor

Overview:
- Sits directly downstream of the 4-bit 8-state sequence counter.
- The counter's sequence is 0000-1110-0111-1111-1101-1011-1001-0110, then repeats.
- The block samples the counter output, hunts for and locks onto that sequence, and flags every deviation.
- It counts completed laps and errors, so the counter can be checked in-system and in simulation without a scoreboard.

Parameters:
- LOCK_N, 3: consecutive correctly chained legal samples required to assert LOCKED. Legal range 2..15.
- LAP_W, 8: width of the saturating lap counter.
- ERR_W, 8: width of the saturating error counter.

Ports:
- CLK  in  1  rising-edge clock (single clock domain).
- CLR  in  1  asynchronous, active-high reset.
- EN  in  1  sample strobe. The block acts only on edges where EN=1.
- SEQ_IN  in  4  counter value under test.
- LOCKED  out  1  high while the tracked stream matches the sequence.
- POS  out  3  sequence index of the last accepted sample. 0 when not locked.
- WRAP  out  1  one-cycle pulse when a locked 0110->0000 transition is accepted.
- ERR  out  1  one-cycle pulse on a mismatch while locked.
- LAPS  out  LAP_W  completed laps, saturating.
- ERRS  out  ERR_W  errors detected, saturating.

Behaviour:
- Reset: one clock CLK; CLR is asynchronous and active-high.
  - CLR=1 immediately forces state HUNT, match_cnt=0, exp_idx=0.
  - It also forces LOCKED=0, POS=0, WRAP=0, ERR=0, LAPS=0, ERRS=0, with no clock edge needed.
  - CLR asserted mid-operation discards all progress.
- Sequence table: idx0=0000, 1=1110, 2=0111, 3=1111, 4=1101, 5=1011, 6=1001, 7=0110.
  - All other codes are illegal: 0001, 0010, 0011, 0100, 0101, 1000, 1010, 1100.
- Timing: all outputs are registered; an EN=1 sample at edge k is reflected in the outputs after edge k.
- EN=0: all state and counters hold; WRAP=0 and ERR=0 on that cycle.
- State machine (3 states). Indices advance modulo 8.
  - HUNT, legal sample idx i: go to VERIFY, exp_idx=i+1, match_cnt=1.
  - HUNT, illegal sample: stay in HUNT, no ERR.
  - VERIFY, SEQ_IN == table[exp_idx]: match_cnt++, exp_idx++. If the new match_cnt == LOCK_N, go to LOCKED, LOCKED=1, POS=accepted idx.
  - VERIFY, legal but out of order: restart VERIFY from that idx, match_cnt=1.
  - VERIFY, illegal: go to HUNT.
  - VERIFY never asserts ERR.
  - LOCKED, match: exp_idx++, POS=accepted idx. If accepted idx==0: WRAP=1 for one cycle and LAPS++.
  - LOCKED, mismatch: ERR=1 for one cycle, ERRS++, LOCKED=0, POS=0. Next state is VERIFY (idx+1, match_cnt=1) if the sample is legal, otherwise HUNT.
- The sample that completes lock never produces WRAP, even if it is 0000.
- Counters saturate at all-ones and never wrap.
- Every sample arrival is classified by exactly one rule above; there are no other simultaneous events.

Decomposition:
- Package seq_stream_pkg holds:
  - the 8-entry sequence table constant;
  - the illegal-code definition;
  - the state encoding (HUNT=0, VERIFY=1, LOCKED=2);
  - the index width constant (3).
- One natural sub-module, seq_code_decode: combinational, 4-bit code in, {legal, idx[2:0]} out. It is used for both the classification and the restart index.

Test Plan:
1. Lock and wrap (LOCK_N=3): CLR pulse, then EN=1 with 0000, 1110, 0111.
   - After the 3rd edge: LOCKED=1, POS=2.
   - Continue through 0110, 0000: WRAP=1 for exactly one cycle, LAPS=1, POS=0.
2. Illegal code while locked: at POS=3, feed 1100 instead of 1101.
   - ERR for one cycle, ERRS=1, LOCKED=0, POS=0.
   - Then 0000, 1110: still unlocked, because HUNT ignored 1100 and only 2 matches have accrued.
   - 0111 relocks.
3. Legal but wrong while locked: at POS=3, feed 1001 (idx6).
   - ERR=1, ERRS=1, VERIFY.
   - Then 0110, 0000: LOCKED=1 with POS=0 on the 0000 sample and no WRAP.
4. EN gating: locked, EN=0 for 10 cycles while SEQ_IN toggles random illegal codes.
   - No ERR, POS/LAPS/ERRS unchanged.
   - EN=1 with the expected next code continues lock.
5. Async reset: locked with LAPS=5, ERRS=2; assert CLR between clock edges.
   - All outputs are 0 before the next CLK edge.
   - Release: state HUNT.
6. Saturation: ERR_W=2, LAP_W=2. Force 5 lock/mismatch errors, then run 5 full laps.
   - ERRS holds 3, LAPS holds 3, and ERR/WRAP pulses still occur on each event.
